// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter that snoops the MIPS
// data-memory port. Stores to TXDATA are queued in a small FIFO and
// serialised LSB first; STATUS reports FIFO fill, overflow and busy state.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        uart_txd,
    output logic        fifo_full,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic          r_txd;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_ovf;

    state_t        w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shreg_nxt;
    logic          w_txd_nxt;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [4:0]    w_cnt5;
    logic          w_unused;

    // Address decode: one 8-byte window, bit 2 picks TXDATA or STATUS
    assign hit        = (dataadr[31:3] == BASE_ADDR[31:3]);
    assign w_push_req = memwrite & hit & ~dataadr[2];
    assign w_ovf_clr  = memwrite & hit & dataadr[2] & writedata[3];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    // A full FIFO still accepts a byte when the transmitter pops in the same cycle
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    // Depth 16 wraps to 0 in the 4-bit count field; full still reads back 1
    assign w_cnt5     = 5'(r_count);
    assign rdata      = hit ? {20'b0, w_cnt5[3:0], 4'b0, r_ovf, tx_busy, w_empty, w_full}
                            : 32'b0;

    assign uart_txd   = r_txd;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_full  = w_full;

    assign w_unused   = &{1'b0, writedata[31:8], dataadr[1:0], w_cnt5[4]};

    // FIFO pointers, fill count and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            // A new overflow wins over a simultaneous clear
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    // FIFO storage and transmit shift register (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= writedata[7:0];
        r_shreg <= w_shreg_nxt;
    end

    // Transmitter state, baud/bit counters and registered serial line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Frame sequencing; txd is computed one cycle ahead so it changes on the state edge
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = r_mem[r_rd];
                    w_baud_nxt  = '0;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_txd_nxt   = r_shreg[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_shreg_nxt = {1'b0, r_shreg[7:1]};
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_txd_nxt   = r_shreg[1];
                    end
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        hit;
    logic [31:0] rdata;
    logic        uart_txd;
    logic        fifo_full;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit       (hit),
        .rdata     (rdata),
        .uart_txd  (uart_txd),
        .fifo_full (fifo_full),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        memwrite = 1'b0;
        dataadr  = BASE + 32'd4;
        #1;
        chk32(tag, rdata, exp);
    endtask

    // Called one step after the edge where the start bit began
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            chk1({tag, "_busy"}, tx_busy, 1'b1);
            for (int c = 0; c < 4; c++) begin
                chk1({tag, "_txd"}, uart_txd, f[k]);
                step();
            end
        end
        chk1({tag, "_idle_busy"}, tx_busy, 1'b0);
        chk1({tag, "_idle_txd"}, uart_txd, 1'b1);
    endtask

    task automatic wait_frame(input string tag, input logic [7:0] b, output int t);
        int n;
        n = 0;
        while (uart_txd !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk1({tag, "_start_seen"}, uart_txd, 1'b0);
        t = cyc;
        check_frame(tag, b);
    endtask

    initial begin
        int t0, t1, t2, t3, t4, tx;

        // Test 1: reset state
        rst       = 1'b1;
        memwrite  = 1'b0;
        dataadr   = BASE + 32'd4;
        writedata = 32'h0;
        #1 rst = 1'b0;
        #1;
        chk1("rst_txd", uart_txd, 1'b1);
        rd_status("rst_status", 32'h0000_0002);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_full", fifo_full, 1'b0);
        chk1("rst_hit", hit, 1'b1);
        repeat (3) step();
        chk1("rst_held_txd", uart_txd, 1'b1);
        rst = 1'b1;
        step();
        chk1("rel_txd", uart_txd, 1'b1);
        rd_status("rel_status", 32'h0000_0002);

        // Test 2: single byte 0xA5, txd falls two edges after the store
        sw(BASE, 32'h0000_00A5);
        chk1("a5_n1_txd", uart_txd, 1'b1);
        step();
        check_frame("a5", 8'hA5);

        // Test 3: overflow while transmitter is busy with a 0xFF frame
        sw(BASE, 32'h0000_00FF);
        step();
        chk1("ff_start", uart_txd, 1'b0);
        sw(BASE, 32'h01);
        sw(BASE, 32'h02);
        sw(BASE, 32'h03);
        sw(BASE, 32'h04);
        sw(BASE, 32'h05);
        rd_status("ovf_status", 32'h0000_040D);
        chk1("ovf_full", fifo_full, 1'b1);
        wait_frame("b01", 8'h01, t1);
        wait_frame("b02", 8'h02, t2);
        chk32("gap12", 32'(t2 - t1), 32'd41);
        wait_frame("b03", 8'h03, t3);
        chk32("gap23", 32'(t3 - t2), 32'd41);
        wait_frame("b04", 8'h04, t4);
        chk32("gap34", 32'(t4 - t3), 32'd41);
        for (int i = 0; i < 12; i++) begin
            chk1("no_b05_txd", uart_txd, 1'b1);
            step();
        end
        rd_status("post_ovf_status", 32'h0000_000A);

        // Test 4: clear overflow, out-of-window store is ignored
        sw(BASE + 32'd4, 32'h0000_0008);
        rd_status("clr_status", 32'h0000_0002);
        memwrite  = 1'b1;
        dataadr   = BASE + 32'd8;
        writedata = 32'h0000_0099;
        #1;
        chk1("miss_hit", hit, 1'b0);
        chk32("miss_rdata", rdata, 32'h0);
        step();
        memwrite = 1'b0;
        dataadr  = BASE + 32'd1;
        #1;
        chk1("byteoff_hit", hit, 1'b1);
        rd_status("miss_status", 32'h0000_0002);
        repeat (3) step();
        chk1("miss_txd", uart_txd, 1'b1);

        // Test 5: store to a full FIFO in the cycle IDLE pops
        sw(BASE, 32'h0000_00FF);
        step();
        chk1("ff2_start", uart_txd, 1'b0);
        t0 = cyc;
        sw(BASE, 32'h11);
        sw(BASE, 32'h22);
        sw(BASE, 32'h33);
        sw(BASE, 32'h44);
        rd_status("full_status", 32'h0000_0405);
        while (cyc < t0 + 40) step();
        chk1("idle_cycle_busy", tx_busy, 1'b0);
        sw(BASE, 32'h55);
        chk1("pp_txd", uart_txd, 1'b0);
        rd_status("pp_status", 32'h0000_0405);
        check_frame("b11", 8'h11);
        wait_frame("b22", 8'h22, tx);
        wait_frame("b33", 8'h33, tx);
        wait_frame("b44", 8'h44, tx);
        wait_frame("b55", 8'h55, tx);
        rd_status("pp_end_status", 32'h0000_0002);

        // Test 6: asynchronous reset during data bit 3
        sw(BASE, 32'h35);
        sw(BASE, 32'h77);
        chk1("r6_start", uart_txd, 1'b0);
        t0 = cyc;
        while (cyc < t0 + 17) step();
        chk1("r6_bit3_txd", uart_txd, 1'b0);
        chk1("r6_bit3_busy", tx_busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("r6_async_txd", uart_txd, 1'b1);
        chk1("r6_async_busy", tx_busy, 1'b0);
        rd_status("r6_status", 32'h0000_0002);
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        chk1("r6_rel_txd", uart_txd, 1'b1);
        rd_status("r6_rel_status", 32'h0000_0002);
        sw(BASE, 32'h0000_00C3);
        chk1("c3_n1_txd", uart_txd, 1'b1);
        step();
        check_frame("c3", 8'hC3);
        for (int i = 0; i < 12; i++) begin
            chk1("no_b77_txd", uart_txd, 1'b1);
            step();
        end
        rd_status("final_status", 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
